y_event_counter: RTL and testbench

Y_EVENT_COUNTER -- requirements
Module: y_event_counter

---
 rtl/yec_if.sv | 22 ++
 rtl/y_event_counter.sv | 134 +++++++++++++
 tb/tb_y_event_counter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/yec_if.sv
// -----------------------------------------------------------------------------
// yec_if -- result handshake between y_event_counter and its consumer.
//
// Signals
//   cnt        result: rising-edge count of Y for the last completed window
//   cnt_valid  cnt holds a result the consumer has not yet accepted
//   cnt_ready  consumer accepts cnt in this cycle
//
// Modports
//   master  the counter side (drives cnt / cnt_valid, samples cnt_ready)
//   slave   the consumer side
// -----------------------------------------------------------------------------
interface yec_if #(
   parameter int CW = 8
);
   logic [CW-1:0] cnt;
   logic          cnt_valid;
   logic          cnt_ready;

   modport master (output cnt, output cnt_valid, input cnt_ready);
   modport slave  (input cnt, input cnt_valid, output cnt_ready);
endinterface : yec_if

// File: rtl/y_event_counter.sv
// -----------------------------------------------------------------------------
// y_event_counter -- counts rising edges of the Mealy output Y over a fixed
// window of enabled clock cycles and offers each window's count to a consumer
// through a valid/ready handshake. Results that arrive while the previous one
// is still pending are dropped and flagged by a sticky overflow bit.
//
// Parameters
//   WINDOW  window length in enabled clk cycles (2..65535)
//   CW      event count width in bits
//
// Ports
//   clk      single clock, rising edge
//   rst      synchronous, active-high reset
//   y_i      Y from the upstream FSM stage
//   en_i     counting enable; low aborts the current window and idles
//   res_if   result handshake (cnt / cnt_valid / cnt_ready), master side
//   ovf_o    sticky: at least one window result was dropped
//
// Configuration macro
//   YEC_SATURATE_EN  when defined, the event count and the loaded result
//                    saturate at 2**CW-1; otherwise they wrap modulo 2**CW.
// -----------------------------------------------------------------------------
module y_event_counter #(
   parameter int WINDOW = 16,
   parameter int CW     = 8
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  y_i,
   input  logic  en_i,
   yec_if.master res_if,
   output logic  ovf_o
);

   localparam int            WW    = $clog2(WINDOW);
   localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t        state_q;
   logic [WW-1:0] wcnt_q;
   logic [CW-1:0] ecnt_q;
   logic          y_d_q;
   logic [CW-1:0] cnt_q;
   logic          cnt_valid_q;
   logic          ovf_q;

   logic          event_d;
   logic [CW-1:0] ecnt_d;
   logic          accept_d;

   // An event is Y rising relative to last cycle's sample. ecnt_d is both the
   // running count for the next cycle and the result loaded at window end, so
   // an event in the final window cycle is included in that window.
   always_comb begin
      event_d  = y_i & ~y_d_q;
      accept_d = cnt_valid_q & res_if.cnt_ready;
`ifdef YEC_SATURATE_EN
      ecnt_d   = (event_d && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
`else
      ecnt_d   = ecnt_q + CW'(event_d);
`endif
   end

   // NOTE: every register here uses <= so all updates see pre-edge values;
   // later assignments in the block deliberately override earlier ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         ecnt_q      <= '0;
         y_d_q       <= 1'b0;
         cnt_q       <= '0;
         cnt_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         y_d_q <= y_i;

         // Handshake completes independently of the window state; a window
         // ending in this same cycle re-asserts cnt_valid below.
         if (accept_d) begin
            cnt_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               // The cycle in which EN rises is already the first window
               // cycle. WINDOW >= 2, so it can never also be the window end.
               if (en_i) begin
                  state_q <= COUNT;
                  wcnt_q  <= wcnt_q + 1'b1;
                  ecnt_q  <= ecnt_d;
               end else begin
                  wcnt_q  <= '0;
                  ecnt_q  <= '0;
               end
            end

            COUNT: begin
               if (!en_i) begin
                  // Abort: the partial window is discarded silently.
                  state_q <= IDLE;
                  wcnt_q  <= '0;
                  ecnt_q  <= '0;
               end else if (wcnt_q == WLAST) begin
                  wcnt_q <= '0;
                  ecnt_q <= '0;
                  if (!cnt_valid_q || res_if.cnt_ready) begin
                     cnt_q       <= ecnt_d;
                     cnt_valid_q <= 1'b1;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
                  ecnt_q <= ecnt_d;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign res_if.cnt       = cnt_q;
   assign res_if.cnt_valid = cnt_valid_q;
   assign ovf_o            = ovf_q;

endmodule : y_event_counter

// File: tb/tb_y_event_counter.sv
// -----------------------------------------------------------------------------
// tb_y_event_counter -- directed bench for y_event_counter.
//
// Instance A: WINDOW=8,  CW=4  (basic count, accept/window-end, abort, drop,
//                               mid-window reset, first post-reset event)
// Instance B: WINDOW=16, CW=2  (saturation vs wrap)
//
// A per-instance reference model tracks the enabled-cycle position and the
// total number of Y rises in the current window as plain integers, and only
// reduces the total to CW bits when a window completes. Every falling clock
// edge the outputs of both instances are compared against it; hand-computed
// literal checks after each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_y_event_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_y = 1'b0, a_en = 1'b0, a_rdy = 1'b0;
   logic b_y = 1'b0, b_en = 1'b0, b_rdy = 1'b0;
   logic a_ovf, b_ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   yec_if #(.CW(4)) if_a ();
   yec_if #(.CW(2)) if_b ();

   assign if_a.cnt_ready = a_rdy;
   assign if_b.cnt_ready = b_rdy;

   y_event_counter #(.WINDOW(8), .CW(4)) u_dut_a (
      .clk    (clk),
      .rst    (rst),
      .y_i    (a_y),
      .en_i   (a_en),
      .res_if (if_a),
      .ovf_o  (a_ovf)
   );

   y_event_counter #(.WINDOW(16), .CW(2)) u_dut_b (
      .clk    (clk),
      .rst    (rst),
      .y_i    (b_y),
      .en_i   (b_en),
      .res_if (if_b),
      .ovf_o  (b_ovf)
   );

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int m_win  [2] = '{8, 16};
   int m_cw   [2] = '{4, 2};
   int m_pos  [2] = '{0, 0};
   int m_evs  [2] = '{0, 0};
   int m_cnt  [2] = '{0, 0};
   bit m_valid[2] = '{0, 0};
   bit m_ovf  [2] = '{0, 0};
   bit m_prev [2] = '{0, 0};

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit yk, ek, rk, accept;
         int res, maxv;
         yk = (k == 0) ? a_y   : b_y;
         ek = (k == 0) ? a_en  : b_en;
         rk = (k == 0) ? a_rdy : b_rdy;
         if (rst) begin
            m_pos[k] = 0; m_evs[k] = 0; m_cnt[k] = 0;
            m_valid[k] = 0; m_ovf[k] = 0; m_prev[k] = 0;
         end else begin
            accept = m_valid[k] && rk;
            if (yk && !m_prev[k]) m_evs[k]++;
            m_prev[k] = yk;
            if (!ek) begin
               m_pos[k] = 0;
               m_evs[k] = 0;
               if (accept) m_valid[k] = 0;
            end else begin
               m_pos[k]++;
               if (m_pos[k] == m_win[k]) begin
                  maxv = (1 << m_cw[k]) - 1;
`ifdef YEC_SATURATE_EN
                  res = (m_evs[k] > maxv) ? maxv : m_evs[k];
`else
                  res = m_evs[k] % (maxv + 1);
`endif
                  if (!m_valid[k] || rk) begin
                     m_cnt[k]   = res;
                     m_valid[k] = 1;
                  end else begin
                     m_ovf[k] = 1;
                  end
                  m_pos[k] = 0;
                  m_evs[k] = 0;
               end else if (accept) begin
                  m_valid[k] = 0;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("a_cnt",       int'(if_a.cnt),       m_cnt[0]);
      check("a_cnt_valid", int'(if_a.cnt_valid), int'(m_valid[0]));
      check("a_ovf",       int'(a_ovf),          int'(m_ovf[0]));
      check("b_cnt",       int'(if_b.cnt),       m_cnt[1]);
      check("b_cnt_valid", int'(if_b.cnt_valid), int'(m_valid[1]));
      check("b_ovf",       int'(b_ovf),          int'(m_ovf[1]));
   end

   // ------------------------------------------------------------- stimulus
   task automatic step_a(input logic y, input logic en, input logic rdy);
      a_y = y; a_en = en; a_rdy = rdy;
      @(negedge clk);
   endtask

   task automatic step_b(input logic y, input logic en, input logic rdy);
      b_y = y; b_en = en; b_rdy = rdy;
      @(negedge clk);
   endtask

   initial begin
      // Reset for two cycles with Y toggling on both instances.
      rst = 1'b1;
      a_y = 1'b1; b_y = 1'b1; a_en = 1'b1;
      @(negedge clk);
      a_y = 1'b0; b_y = 1'b0;
      @(negedge clk);
      check("reset_cnt",   int'(if_a.cnt),       0);
      check("reset_valid", int'(if_a.cnt_valid), 0);
      check("reset_ovf",   int'(a_ovf),          0);
      rst = 1'b0;

      fork
         begin : seq_a
            // Basic count: Y alternating 0,1 -> 4 events per window.
            for (int i = 0; i < 8; i++) step_a(i[0], 1'b1, 1'b1);
            check("basic_cnt",   int'(if_a.cnt),       4);
            check("basic_valid", int'(if_a.cnt_valid), 1);
            for (int i = 0; i < 8; i++) step_a(i[0], 1'b1, 1'b1);
            check("repeat_cnt",  int'(if_a.cnt),       4);

            // Accept coincides with window end holding 3 events.
            for (int i = 0; i < 8; i++) step_a((i < 6) ? i[0] : 1'b0, 1'b1, i == 7);
            check("simul_cnt",   int'(if_a.cnt),       3);
            check("simul_valid", int'(if_a.cnt_valid), 1);
            check("simul_ovf",   int'(a_ovf),          0);

            // Abort after 4 cycles with 2 events, then a full window with 1.
            step_a(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 4; i++) step_a(i[0], 1'b1, 1'b1);
            step_a(1'b0, 1'b0, 1'b1);
            step_a(1'b0, 1'b0, 1'b1);
            check("abort_valid", int'(if_a.cnt_valid), 0);
            for (int i = 0; i < 8; i++) step_a(i == 2 || i == 3, 1'b1, 1'b1);
            check("abort_cnt",   int'(if_a.cnt),       1);

            // Dropped result: 4 events loaded, then 2 events dropped.
            step_a(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 8; i++) step_a(i[0], 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) step_a((i < 4) ? i[0] : 1'b0, 1'b1, 1'b0);
            check("drop_cnt",    int'(if_a.cnt),       4);
            check("drop_valid",  int'(if_a.cnt_valid), 1);
            check("drop_ovf",    int'(a_ovf),          1);
            step_a(1'b0, 1'b0, 1'b0);
         end
         begin : seq_b
            // 8 events in a 16-cycle window with a 2-bit count.
            for (int i = 0; i < 16; i++) step_b(i[0], 1'b1, 1'b1);
`ifdef YEC_SATURATE_EN
            check("sat_cnt",   int'(if_b.cnt), 3);
`else
            check("wrap_cnt",  int'(if_b.cnt), 0);
`endif
            check("b_valid",   int'(if_b.cnt_valid), 1);
            step_b(1'b0, 1'b0, 1'b0);
         end
      join

      // Reset mid-window, with a pending result and OVF set.
      for (int i = 0; i < 3; i++) step_a(i[0], 1'b1, 1'b0);
      rst = 1'b1;
      step_a(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      check("midrst_cnt",   int'(if_a.cnt),       0);
      check("midrst_valid", int'(if_a.cnt_valid), 0);
      check("midrst_ovf",   int'(a_ovf),          0);

      // Y=1 in the first post-reset cycle is an event.
      for (int i = 0; i < 8; i++) step_a(i == 0, 1'b1, 1'b1);
      check("first_evt_cnt",   int'(if_a.cnt),       1);
      check("first_evt_valid", int'(if_a.cnt_valid), 1);

      step_a(1'b0, 1'b0, 1'b1);
      step_a(1'b0, 1'b0, 1'b1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_y_event_counter
